// File: rtl/sd_nios_hw_port_pkg.sv
// Shared register map, CTRL bit positions and handshake state type for the NIOS hardware output port.
package sd_nios_hw_port_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_SET     = 3'd1;
  localparam logic [2:0] ADDR_CLR     = 3'd2;
  localparam logic [2:0] ADDR_TGL     = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd5;
  localparam logic [2:0] ADDR_PULSE   = 3'd6;
  localparam logic [2:0] ADDR_IRQMASK = 3'd7;

  localparam int CTRL_COMMIT     = 0;
  localparam int CTRL_AUTO       = 1;
  localparam int CTRL_ACK_STICKY = 2;
  localparam int CTRL_PENDING    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    PEND  = 2'd2
  } hw_state_e;

endpackage

// File: rtl/sd_nios_hw_port_mm_if.sv
// Avalon-MM slave bus plus the hardware-side output handshake of sd_nios_hw_port_mm.
interface sd_nios_hw_port_mm_if #(
  parameter int DATA_WIDTH = 16
);
  logic [2:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic                  read_n;
  logic [31:0]           writedata;
  logic [3:0]            byteenable;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_port;
  logic                  out_valid;
  logic                  out_ack;
  logic                  out_pulse;

  // Handshake: out_valid rises together with a new out_port value; both hold
  // steady until a rising edge where out_ack=1. out_ack is ignored while out_valid=0.
  modport master (
    output address, chipselect, write_n, read_n, writedata, byteenable, out_ack,
    input  readdata, out_port, out_valid, out_pulse
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata, byteenable, out_ack,
    output readdata, out_port, out_valid, out_pulse
  );
endinterface

// File: rtl/sd_nios_pulse_gen.sv
// Strobe counter: load N (0 aborts), then count down; the pulse is high while the count is nonzero.
module sd_nios_pulse_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_pulse
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_pulse = (r_cnt != '0);

endmodule

// File: rtl/sd_nios_hw_port_mm.sv
// Double-buffered NIOS output port: shadow register with set/clear/toggle, commit handshake, strobe.
// Optional ack interrupt is built when HW_PORT_ACK_IRQ_EN is defined.
module sd_nios_hw_port_mm
  import sd_nios_hw_port_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    PULSE_CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  sd_nios_hw_port_mm_if.slave bus,
`ifdef HW_PORT_ACK_IRQ_EN
  output logic                irq,
`endif
  output hw_state_e           o_dbg_state
);

  logic                   w_wr;
  logic                   w_rd;
  logic                   w_ctrl_wr;
  logic                   w_commit;
  logic                   w_ack;
  logic                   w_load;
  logic                   w_irqmask_rd;
  logic [DATA_WIDTH-1:0]  w_wd;
  logic [DATA_WIDTH-1:0]  w_be_mask;
  logic [DATA_WIDTH-1:0]  w_shadow_next;
  logic [PULSE_CNT_W-1:0] w_cnt;
  logic                   w_pulse;
  logic [31:0]            w_rdata;
  hw_state_e              w_state_next;

  hw_state_e              r_state;
  logic [DATA_WIDTH-1:0]  r_shadow;
  logic [DATA_WIDTH-1:0]  r_active;
  logic                   r_auto;
  logic                   r_ack_sticky;
  logic [31:0]            r_readdata;

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_rd      = bus.chipselect & ~bus.read_n;
  assign w_ctrl_wr = w_wr & (bus.address == ADDR_CTRL);
  assign w_wd      = bus.writedata[DATA_WIDTH-1:0];

  always_comb begin
    w_be_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_be_mask[i] = bus.byteenable[i[4:3]];
    end
  end

  always_comb begin
    w_shadow_next = r_shadow;
    if (w_wr) begin
      case (bus.address)
        ADDR_DATA: w_shadow_next = (r_shadow & ~w_be_mask) | (w_wd & w_be_mask);
        ADDR_SET:  w_shadow_next = r_shadow | w_wd;
        ADDR_CLR:  w_shadow_next = r_shadow & ~w_wd;
        ADDR_TGL:  w_shadow_next = r_shadow ^ w_wd;
        default:   w_shadow_next = r_shadow;
      endcase
    end
  end

  // AUTO turns any shadow-register write (addresses 0-3) into a commit of the new value.
  assign w_commit = (w_ctrl_wr & bus.writedata[CTRL_COMMIT]) |
                    (w_wr & r_auto & ~bus.address[2]);
  assign w_ack    = bus.out_ack & (r_state != IDLE);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_commit) begin
          w_state_next = VALID;
          w_load       = 1'b1;
        end
      end
      VALID: begin
        if (w_ack) begin
          w_state_next = w_commit ? VALID : IDLE;
          w_load       = w_commit;
        end else if (w_commit) begin
          w_state_next = PEND;
        end
      end
      PEND: begin
        if (w_ack) begin
          w_state_next = VALID;
          w_load       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_shadow     <= RESET_VALUE;
      r_active     <= RESET_VALUE;
      r_auto       <= 1'b0;
      r_ack_sticky <= 1'b0;
      r_readdata   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_shadow <= w_shadow_next;
      if (w_load) r_active <= w_shadow_next;
      if (w_ctrl_wr) r_auto <= bus.writedata[CTRL_AUTO];
      if (w_ack) begin
        r_ack_sticky <= 1'b1;
      end else if (w_ctrl_wr && bus.writedata[CTRL_ACK_STICKY]) begin
        r_ack_sticky <= 1'b0;
      end
      r_readdata <= w_rd ? w_rdata : '0;
    end
  end

`ifdef HW_PORT_ACK_IRQ_EN
  logic r_irqmask;
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && (bus.address == ADDR_IRQMASK)) r_irqmask <= bus.writedata[0];
      r_irq <= r_ack_sticky & r_irqmask;
    end
  end

  assign irq          = r_irq;
  assign w_irqmask_rd = r_irqmask;
`else
  assign w_irqmask_rd = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA:    w_rdata = 32'(r_shadow);
      ADDR_CTRL: begin
        w_rdata[CTRL_COMMIT]     = (r_state != IDLE);
        w_rdata[CTRL_AUTO]       = r_auto;
        w_rdata[CTRL_ACK_STICKY] = r_ack_sticky;
        w_rdata[CTRL_PENDING]    = (r_state == PEND);
      end
      ADDR_ACTIVE:  w_rdata = 32'(r_active);
      ADDR_PULSE:   w_rdata = 32'(w_cnt);
      ADDR_IRQMASK: w_rdata[0] = w_irqmask_rd;
      default:      w_rdata = '0;
    endcase
  end

  sd_nios_pulse_gen #(
    .CNT_W(PULSE_CNT_W)
  ) u_pulse_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_wr && (bus.address == ADDR_PULSE)),
    .i_load_val (bus.writedata[PULSE_CNT_W-1:0]),
    .o_cnt      (w_cnt),
    .o_pulse    (w_pulse)
  );

  assign bus.readdata  = r_readdata;
  assign bus.out_port  = r_active;
  assign bus.out_valid = (r_state != IDLE);
  assign bus.out_pulse = w_pulse;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sd_nios_hw_port_mm.sv
// Bench for sd_nios_hw_port_mm: directed scenarios plus random traffic against a transaction-level model.
module tb_sd_nios_hw_port_mm;
  import sd_nios_hw_port_pkg::*;

  localparam int             DW = 16;
  localparam int             PW = 16;
  localparam logic [DW-1:0]  RV = '0;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sd_nios_hw_port_mm_if #(.DATA_WIDTH(DW)) bus ();
  hw_state_e dbg_state;
`ifdef HW_PORT_ACK_IRQ_EN
  logic irq;
`endif

  sd_nios_hw_port_mm #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (RV),
    .PULSE_CNT_W (PW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
`ifdef HW_PORT_ACK_IRQ_EN
    .irq         (irq),
`endif
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard queues
  logic [31:0]   exp_q[$];
  logic [2:0]    exp_a_q[$];
  logic [DW+2:0] out_q[$];

  // reference model state
  logic [DW-1:0] m_shadow, m_active;
  logic [31:0]   m_cnt;
  bit            m_valid, m_pend, m_auto, m_sticky, m_mask, m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = RV; m_active = RV; m_cnt = 0;
    m_valid = 0; m_pend = 0; m_auto = 0; m_sticky = 0; m_mask = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v = 32'(m_shadow);
      3'd4: v = {28'd0, m_pend, m_sticky, m_auto, m_valid || m_pend};
      3'd5: v = 32'(m_active);
      3'd6: v = m_cnt;
      3'd7: v = {31'd0, m_mask};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step(input bit wr, input logic [2:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input bit ack);
    logic [31:0]   full;
    logic [DW-1:0] sh;
    bit            commit, acked, ctrl_wr;
    sh = m_shadow;
    if (wr) begin
      case (a)
        3'd0: begin
          full = 32'(m_shadow);
          for (int b = 0; b < 4; b++) if (be[b]) full[8*b +: 8] = wd[8*b +: 8];
          sh = full[DW-1:0];
        end
        3'd1: sh = m_shadow | wd[DW-1:0];
        3'd2: sh = m_shadow & ~wd[DW-1:0];
        3'd3: sh = m_shadow ^ wd[DW-1:0];
        default: ;
      endcase
    end
    ctrl_wr = wr && (a == 3'd4);
    commit  = (ctrl_wr && wd[0]) || (wr && m_auto && (a < 3'd4));
    acked   = ack && m_valid;
    m_irq   = m_sticky && m_mask;
    if (acked) begin
      if (m_pend) begin
        m_active = sh;
        m_pend   = 0;
      end else if (commit) begin
        m_active = sh;
      end else begin
        m_valid = 0;
      end
    end else if (commit) begin
      if (!m_valid) begin
        m_active = sh;
        m_valid  = 1;
      end else begin
        m_pend = 1;
      end
    end
    if (acked) m_sticky = 1;
    else if (ctrl_wr && wd[2]) m_sticky = 0;
    if (ctrl_wr) m_auto = wd[1];
`ifdef HW_PORT_ACK_IRQ_EN
    if (wr && (a == 3'd7)) m_mask = wd[0];
`endif
    if (wr && (a == 3'd6)) m_cnt = 32'(wd[PW-1:0]);
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    m_shadow = sh;
  endtask

  // driver: one bus cycle, entered and left at posedge+1
  task automatic cycle(input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit ack);
    bus.chipselect = wr | rd;
    bus.write_n    = ~wr;
    bus.read_n     = ~rd;
    bus.address    = a;
    bus.writedata  = wd;
    bus.byteenable = be;
    bus.out_ack    = ack;
    if (rd) begin
      exp_q.push_back(model_read(a));
      exp_a_q.push_back(a);
    end
    @(posedge clk);
    #1;
    model_step(wr, a, wd, be, ack);
    out_q.push_back({m_irq, (m_cnt != 0), m_valid, m_active});
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    bus.out_ack    = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, a, d, 4'hF, 1'b0);
  endtask

  task automatic do_read(input logic [2:0] a);
    cycle(1'b0, 1'b1, a, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic do_idle(input bit ack);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'h0, ack);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " out_pulse"}, 32'(bus.out_pulse), 32'd0);
    check({tag, " out_port"},  32'(bus.out_port),  32'(RV));
    check({tag, " readdata"},  bus.readdata,       32'd0);
    check({tag, " state"},     32'(dbg_state),     32'(IDLE));
`ifdef HW_PORT_ACK_IRQ_EN
    check({tag, " irq"},       32'(irq),           32'd0);
`endif
  endtask

  // Asynchronous reset in the middle of a clock phase, then clean release.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // monitor
  logic          rd_d;
  logic [DW+2:0] mon_e;
  logic [31:0]   mon_r;
  logic [2:0]    mon_a;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_d <= 1'b0;
    else          rd_d <= bus.chipselect & ~bus.read_n;
  end

  always @(negedge clk) begin
    if (out_q.size() > 0) begin
      mon_e = out_q.pop_front();
      check("out_port",  32'(bus.out_port),  32'(mon_e[DW-1:0]));
      check("out_valid", 32'(bus.out_valid), 32'(mon_e[DW]));
      check("out_pulse", 32'(bus.out_pulse), 32'(mon_e[DW+1]));
`ifdef HW_PORT_ACK_IRQ_EN
      check("irq",       32'(irq),           32'(mon_e[DW+2]));
`endif
    end
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL readdata: got %h with no read expected", bus.readdata);
      end else begin
        mon_r = exp_q.pop_front();
        mon_a = exp_a_q.pop_front();
        check($sformatf("readdata addr%0d", mon_a), bus.readdata, mon_r);
      end
    end
  end

  int hi_cnt;

  initial begin
    logic [2:0]  ra;
    logic [31:0] rd;
    int          op;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
    bus.byteenable = 4'd0;
    bus.out_ack    = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i <= 6; i++) do_read(3'(i));

    // byte-lane write, commit, ack
    cycle(1'b1, 1'b0, 3'd0, 32'h0000A5A5, 4'b0001, 1'b0);
    do_write(3'd4, 32'h1);
    check("commit out_port", 32'(bus.out_port), 32'h00A5);
    do_idle(1'b1);
    do_read(3'd4);

    // set/clear/toggle only touch the shadow
    do_write(3'd1, 32'h0F00);
    do_write(3'd2, 32'h0005);
    do_write(3'd3, 32'h8000);
    do_read(3'd0);
    do_read(3'd5);

    // commit, commit again while unacked -> pending
    do_write(3'd4, 32'h1);
    do_write(3'd0, 32'h1234);
    do_write(3'd4, 32'h1);
    do_read(3'd4);
    do_idle(1'b1);
    check("pend ack out_port", 32'(bus.out_port), 32'h1234);
    do_read(3'd4);

    // commit and ack together while valid
    do_write(3'd0, 32'h5A5A);
    cycle(1'b1, 1'b0, 3'd4, 32'h5, 4'hF, 1'b1);
    do_read(3'd4);
    do_idle(1'b1);

    // strobe length
    do_write(3'd6, 32'd5);
    hi_cnt = int'(bus.out_pulse);
    for (int i = 0; i < 9; i++) begin
      do_idle(1'b0);
      hi_cnt += int'(bus.out_pulse);
    end
    check("pulse5 length", 32'(hi_cnt), 32'd5);
    do_write(3'd6, 32'd5);
    hi_cnt = int'(bus.out_pulse);
    do_idle(1'b0);
    hi_cnt += int'(bus.out_pulse);
    do_write(3'd6, 32'd3);
    hi_cnt += int'(bus.out_pulse);
    for (int i = 0; i < 6; i++) begin
      do_idle(1'b0);
      hi_cnt += int'(bus.out_pulse);
    end
    check("pulse reload length", 32'(hi_cnt), 32'd5);
    do_write(3'd6, 32'hABCD_000A);
    do_idle(1'b0);
    do_read(3'd6);
    do_write(3'd6, 32'd0);
    check("pulse abort", 32'(bus.out_pulse), 32'd0);

    // AUTO commit
    do_write(3'd4, 32'h6);
    do_write(3'd0, 32'h0001);
    check("auto out_valid", 32'(bus.out_valid), 32'd1);
    check("auto out_port",  32'(bus.out_port),  32'h0001);
`ifdef HW_PORT_ACK_IRQ_EN
    do_write(3'd7, 32'h1);
    do_idle(1'b1);
    do_idle(1'b0);
    check("irq after ack", 32'(irq), 32'd1);
    do_write(3'd4, 32'h6);
    do_idle(1'b0);
    check("irq after w1c", 32'(irq), 32'd0);
`endif
    do_write(3'd4, 32'h0);

    // reset while pending
    do_write(3'd4, 32'h1);
    do_write(3'd0, 32'h7777);
    do_write(3'd4, 32'h1);
    pulse_reset("rst pend");
    do_read(3'd4);
    do_read(3'd0);

    // reset while strobing
    do_write(3'd6, 32'd20);
    do_idle(1'b0);
    pulse_reset("rst pulse");
    do_read(3'd6);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 9);
      ra = 3'($urandom_range(0, 7));
      case (ra)
        3'd4:    rd = 32'($urandom_range(0, 7));
        3'd6:    rd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
        default: rd = $urandom;
      endcase
      if (op <= 3)      cycle(1'b1, 1'b0, ra, rd, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      else if (op <= 6) cycle(1'b0, 1'b1, ra, 32'd0, 4'd0, ($urandom_range(0, 3) == 0));
      else              do_idle($urandom_range(0, 2) == 0);
    end

    do_idle(1'b0);
    do_idle(1'b0);
    @(negedge clk);
    #1 check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
